// File: rtl/pwm_channel_bank.sv
// Multi-channel PWM with a shared prescaled timebase, edge- or center-aligned.
// Top, compare and mode are shadowed and only change at a period boundary.
//
// dir state | meaning
// DIR_UP    | counting up (always the case in edge mode and at every boundary)
// DIR_DOWN  | center-aligned descent from shadowTop-1 towards 1
module pwm_channel_bank #(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      centerAligned,
    input  logic [PRESCALE_WIDTH-1:0] prescaleValue,
    input  logic [WIDTH-1:0]          topValue,
    input  logic [CHANNELS*WIDTH-1:0] compareValues,
    input  logic [CHANNELS-1:0]       channelEnable,
    input  logic [CHANNELS-1:0]       invert,
    output logic [WIDTH-1:0]          counterValue,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS-1:0]       compareRise,
    output logic [CHANNELS-1:0]       compareFall,
    output logic                      periodStart
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0]          count_q, count_d;
    dir_e                      dir_q, dir_d;
    logic [WIDTH-1:0]          shadow_top_q;
    logic [CHANNELS*WIDTH-1:0] shadow_cmp_q;
    logic                      shadow_center_q;
    logic [CHANNELS-1:0]       state_q, state_d;
    logic [CHANNELS-1:0]       last_q;
    logic                      period_start_q;
    logic                      tick;
    logic                      boundary;
    logic                      load_shadow;

    assign tick = enable && (ps_q == prescaleValue);

    // A shrunken prescaleValue below ps_q lets ps_q run on and wrap naturally.
    always_comb begin
        ps_d = ps_q + PRESCALE_WIDTH'(1);
        if (!enable || tick) begin
            ps_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        if (shadow_top_q == '0) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else if (!shadow_center_q) begin
            dir_d   = DIR_UP;
            count_d = (count_q == shadow_top_q) ? '0 : count_q + WIDTH'(1);
        end else if (dir_q == DIR_UP) begin
            if (count_q == shadow_top_q) begin
                count_d = shadow_top_q - WIDTH'(1);
                // top==1 folds straight back to 0, which is itself the boundary
                dir_d   = (shadow_top_q == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
                dir_d = DIR_UP;
            end
        end
    end

    // Every return of the count to 0 on a tick starts a new period.
    assign boundary    = tick && (count_d == '0);
    assign load_shadow = boundary || !enable;

    always_comb begin
        state_d = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            state_d[n] = enable && channelEnable[n] &&
                         (count_q < shadow_cmp_q[n*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q            <= '0;
            count_q         <= '0;
            dir_q           <= DIR_UP;
            shadow_top_q    <= '0;
            shadow_cmp_q    <= '0;
            shadow_center_q <= 1'b0;
            state_q         <= '0;
            last_q          <= '0;
            period_start_q  <= 1'b0;
        end else begin
            ps_q <= ps_d;
            if (!enable) begin
                count_q <= '0;
                dir_q   <= DIR_UP;
            end else if (tick) begin
                count_q <= count_d;
                dir_q   <= dir_d;
            end
            if (load_shadow) begin
                shadow_top_q    <= topValue;
                shadow_cmp_q    <= compareValues;
                shadow_center_q <= centerAligned;
            end
            state_q        <= state_d;
            last_q         <= state_q;
            period_start_q <= boundary;
        end
    end

    assign counterValue = count_q;
    assign pwm_out      = state_q ^ invert;
    assign compareRise  = state_q & ~last_q;
    assign compareFall  = ~state_q & last_q;
    assign periodStart  = period_start_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Bench for pwm_channel_bank: a period/phase model checked every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_pwm_channel_bank;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int PW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              centerAligned;
    logic [PW-1:0]     prescaleValue;
    logic [W-1:0]      topValue;
    logic [CH*W-1:0]   compareValues;
    logic [CH-1:0]     channelEnable;
    logic [CH-1:0]     invert;
    logic [W-1:0]      counterValue;
    logic [CH-1:0]     pwm_out;
    logic [CH-1:0]     compareRise;
    logic [CH-1:0]     compareFall;
    logic              periodStart;

    pwm_channel_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .centerAligned(centerAligned),
        .prescaleValue(prescaleValue), .topValue(topValue),
        .compareValues(compareValues), .channelEnable(channelEnable),
        .invert(invert), .counterValue(counterValue), .pwm_out(pwm_out),
        .compareRise(compareRise), .compareFall(compareFall),
        .periodStart(periodStart)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int hi[CH];
    int rise_n[CH];
    int fall_n[CH];
    int pst_n;

    // Model: position within the period (phase) plus the shadowed config.
    int          m_ps = 0;
    int          m_phase = 0;
    int          m_top = 0;
    bit          m_center = 1'b0;
    int          m_cmp[CH];
    logic [CH-1:0] m_state = '0;
    logic [CH-1:0] m_last = '0;
    bit          m_pstart = 1'b0;

    function automatic int plen(int top, bit c);
        if (top == 0) return 1;
        return c ? 2 * top : top + 1;
    endfunction

    function automatic int mcount(int p, int top, bit c);
        if (!c) return p;
        return (p <= top) ? p : 2 * top - p;
    endfunction

    task automatic load_model_shadows();
        m_top    = int'(topValue);
        m_center = centerAligned;
        for (int c = 0; c < CH; c++) m_cmp[c] = int'(compareValues[c*W +: W]);
    endtask

    always @(posedge clk) begin
        logic [CH-1:0] st;
        if (rst) begin
            m_ps = 0; m_phase = 0; m_top = 0; m_center = 1'b0;
            for (int c = 0; c < CH; c++) m_cmp[c] = 0;
            m_state = '0; m_last = '0; m_pstart = 1'b0;
        end else if (!enable) begin
            m_ps = 0; m_phase = 0;
            load_model_shadows();
            m_last = m_state; m_state = '0; m_pstart = 1'b0;
        end else begin
            for (int c = 0; c < CH; c++)
                st[c] = channelEnable[c] && (mcount(m_phase, m_top, m_center) < m_cmp[c]);
            m_last   = m_state;
            m_state  = st;
            m_pstart = 1'b0;
            if (m_ps == int'(prescaleValue)) begin
                m_ps = 0;
                if (m_phase + 1 >= plen(m_top, m_center)) begin
                    m_phase  = 0;
                    m_pstart = 1'b1;
                    load_model_shadows();
                end else begin
                    m_phase = m_phase + 1;
                end
            end else begin
                m_ps = (m_ps + 1) % (1 << PW);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < CH; c++) begin
            hi[c] = 0; rise_n[c] = 0; fall_n[c] = 0;
        end
        pst_n = 0;
    endtask

    task automatic step();
        @(negedge clk);
        chk("model_counter", 32'(counterValue), 32'(mcount(m_phase, m_top, m_center)));
        chk("model_pwm_out", 32'(pwm_out), 32'(m_state ^ invert));
        chk("model_rise", 32'(compareRise), 32'(m_state & ~m_last));
        chk("model_fall", 32'(compareFall), 32'(~m_state & m_last));
        chk("model_period_start", 32'(periodStart), 32'(m_pstart));
        for (int c = 0; c < CH; c++) begin
            hi[c]     += int'(pwm_out[c]);
            rise_n[c] += int'(compareRise[c]);
            fall_n[c] += int'(compareFall[c]);
        end
        pst_n += int'(periodStart);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cmp(input int ch, input int v);
        compareValues[ch*W +: W] = W'(v);
    endtask

    initial begin
        int exp_c[8];
        int exp_t1[4];
        rst = 1'b1; enable = 1'b0; centerAligned = 1'b0; prescaleValue = '0;
        topValue = '0; compareValues = '0; channelEnable = '0; invert = 4'b1010;
        clear_stats();
        steps(2);
        chk("rst_pwm_is_invert", 32'(pwm_out), 32'h0000000A);
        chk("rst_counter", 32'(counterValue), 32'd0);

        // edge-aligned, top 9, compare 3
        rst = 1'b0; topValue = 16'd9; set_cmp(0, 3); channelEnable = 4'b0001; invert = '0;
        step();
        enable = 1'b1;
        clear_stats();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("edge_seq", 32'(counterValue), 32'((i + 1) % 10));
        end
        steps(10);
        chk("edge_hi", 32'(hi[0]), 32'd6);
        chk("edge_rise", 32'(rise_n[0]), 32'd2);
        chk("edge_fall", 32'(fall_n[0]), 32'd2);
        chk("edge_pstart", 32'(pst_n), 32'd2);

        // double buffering: compare 3 -> 7 at counter 5
        steps(5);
        chk("dbuf_at5", 32'(counterValue), 32'd5);
        set_cmp(0, 7);
        clear_stats();
        steps(5);
        chk("dbuf_old_low", 32'(hi[0]), 32'd0);
        chk("dbuf_pstart", 32'(pst_n), 32'd1);
        clear_stats();
        steps(10);
        chk("dbuf_new_hi", 32'(hi[0]), 32'd7);
        chk("dbuf_rise", 32'(rise_n[0]), 32'd1);
        chk("dbuf_fall", 32'(fall_n[0]), 32'd1);

        // extremes
        enable = 1'b0;
        set_cmp(0, 0); set_cmp(1, 10); set_cmp(2, 0); set_cmp(3, 5);
        channelEnable = 4'b0111; invert = 4'b1100;
        step();
        enable = 1'b1;
        clear_stats();
        steps(20);
        chk("ext_cmp0_hi", 32'(hi[0]), 32'd0);
        chk("ext_cmp0_rise", 32'(rise_n[0]), 32'd0);
        chk("ext_cmp10_hi", 32'(hi[1]), 32'd20);
        chk("ext_cmp10_rise", 32'(rise_n[1]), 32'd1);
        chk("ext_inv_hi", 32'(hi[2]), 32'd20);
        chk("ext_chdis_hi", 32'(hi[3]), 32'd20);

        // prescale 2
        enable = 1'b0; prescaleValue = 8'd2; compareValues = '0; set_cmp(0, 3);
        channelEnable = 4'b0001; invert = '0;
        step();
        enable = 1'b1;
        clear_stats();
        steps(2);
        chk("ps_hold", 32'(counterValue), 32'd0);
        step();
        chk("ps_adv", 32'(counterValue), 32'd1);
        steps(57);
        chk("ps_pstart", 32'(pst_n), 32'd2);
        chk("ps_hi", 32'(hi[0]), 32'd18);
        chk("ps_rise", 32'(rise_n[0]), 32'd2);
        prescaleValue = 8'd6;
        steps(4);
        prescaleValue = 8'd1;
        steps(260);

        // center-aligned, top 4, compare 2
        enable = 1'b0; prescaleValue = '0; centerAligned = 1'b1; topValue = 16'd4; set_cmp(0, 2);
        step();
        enable = 1'b1;
        clear_stats();
        exp_c = '{1, 2, 3, 4, 3, 2, 1, 0};
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ctr_seq", 32'(counterValue), 32'(exp_c[i]));
        end
        steps(8);
        chk("ctr_hi", 32'(hi[0]), 32'd6);
        chk("ctr_pstart", 32'(pst_n), 32'd2);

        // center-aligned, top 1
        enable = 1'b0; topValue = 16'd1;
        step();
        enable = 1'b1;
        clear_stats();
        exp_t1 = '{1, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ctr_top1_seq", 32'(counterValue), 32'(exp_t1[i]));
        end
        chk("ctr_top1_pstart", 32'(pst_n), 32'd2);

        // top 0
        enable = 1'b0; topValue = '0; centerAligned = 1'b0;
        step();
        enable = 1'b1;
        clear_stats();
        steps(5);
        chk("top0_pstart", 32'(pst_n), 32'd5);
        chk("top0_counter", 32'(counterValue), 32'd0);

        // mid-period reset and enable drop
        enable = 1'b0; topValue = 16'd9; set_cmp(0, 8); channelEnable = 4'b0001; invert = 4'b0010;
        step();
        enable = 1'b1;
        steps(6);
        chk("dis_at6", 32'(counterValue), 32'd6);
        rst = 1'b1;
        step();
        chk("dis_rst_counter", 32'(counterValue), 32'd0);
        chk("dis_rst_pwm", 32'(pwm_out), 32'h00000002);
        chk("dis_rst_rise", 32'(compareRise), 32'd0);
        chk("dis_rst_fall", 32'(compareFall), 32'd0);
        chk("dis_rst_pstart", 32'(periodStart), 32'd0);
        rst = 1'b0;
        steps(3);
        chk("dis_ch0_high", 32'(pwm_out[0]), 32'd1);
        enable = 1'b0;
        clear_stats();
        step();
        chk("dis_counter0", 32'(counterValue), 32'd0);
        chk("dis_fall_pulse", 32'(compareFall[0]), 32'd1);
        chk("dis_ch0_low", 32'(pwm_out[0]), 32'd0);
        steps(2);
        chk("dis_fall_once", 32'(fall_n[0]), 32'd1);
        enable = 1'b1;
        clear_stats();
        step();
        chk("reen_counter", 32'(counterValue), 32'd1);
        steps(8);
        chk("reen_no_pstart", 32'(pst_n), 32'd0);
        step();
        chk("reen_first_pstart", 32'(pst_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_channel_bank.md
# pwm_channel_bank

Multi-channel PWM generator with its own timebase. It contains a prescaled counter shared by `CHANNELS` outputs and supports edge-aligned and center-aligned modes. Top and compare values are double-buffered and take effect only at a period boundary, and each channel has its own polarity control. It sits behind the PWM peripheral's register interface and replaces per-channel single-compare outputs fed by an external counter.

## Interface
- `WIDTH`, 16, counter/compare width
- `CHANNELS`, 4, number of PWM channels
- `PRESCALE_WIDTH`, 8, prescaler width

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  run timebase; low holds everything idle
- `centerAligned`  in  1  0 = edge-aligned, 1 = center-aligned
- `prescaleValue`  in  PRESCALE_WIDTH  counter advances every prescaleValue+1 clocks
- `topValue`  in  WIDTH  counter maximum
- `compareValues`  in  CHANNELS*WIDTH  channel n at [n*WIDTH +: WIDTH]
- `channelEnable`  in  CHANNELS  per-channel enable
- `invert`  in  CHANNELS  per-channel output polarity
- `counterValue`  out  WIDTH  current timebase count
- `pwm_out`  out  CHANNELS  PWM outputs
- `compareRise`  out  CHANNELS  1-clk pulse, channel state 0→1
- `compareFall`  out  CHANNELS  1-clk pulse, channel state 1→0
- `periodStart`  out  1  1-clk pulse at each new period

## Operation
- Prescaler and tick:
  - psCount counts 0..prescaleValue.
  - tick = enable && psCount==prescaleValue; psCount returns to 0 on tick.
- Shadow registers:
  - shadowTop, shadowCompare[n] and shadowMode are loaded from the inputs on every boundary tick.
  - They are also loaded on every clock while enable=0.
  - Input changes at any other time have no effect.
- Edge mode:
  - On tick, the counter increments.
  - At counter==shadowTop the tick is a boundary: counter←0.
  - Period = shadowTop+1 ticks.
- Center mode:
  - Direction is up from 0 to shadowTop, then down.
  - On a tick at counter==shadowTop while counting up: direction←down, counter←shadowTop−1.
  - On a tick at counter==1 while counting down: boundary, counter←0, direction←up.
  - Period = 2·shadowTop ticks.
  - shadowTop==1 gives 0,1,0,1…
- shadowTop==0 (either mode): counter stays 0 and every tick is a boundary.
- The counter can never exceed shadowTop, because the shadow updates only while counter==0.
- Channel state:
  - state[n] ← channelEnable[n] && (counterValue < shadowCompare[n]).
  - It is registered every clk while enable=1, so compare 0 gives a constant low state.
  - compare > shadowTop gives a constant high state.
  - enable=0 forces state←0.
- Outputs:
  - pwm_out[n] = state[n] ^ invert[n] (combinational XOR after the register).
  - lastState[n] is state delayed one clk.
  - compareRise = state && !lastState; compareFall = !state && lastState. Both use the pre-inversion state.
- periodStart: registered, high for one clk in the cycle after a boundary tick. No pulse on the enable rising edge.
- enable=0 holds counter, psCount and state at 0 and direction at up; the shadows track the inputs.

## Timing
- Reset values:
  - counterValue=0, psCount=0, direction up, shadows 0.
  - state, lastState, compareRise, compareFall and periodStart are all 0.
  - pwm_out = invert (combinational).
- counterValue updates on the clk edge of a tick.
- state follows the counterValue that held during the previous cycle, so pwm_out lags counterValue by 1 clk.
- compareRise/compareFall assert in the same cycle pwm_out changes; each pulse lasts 1 clk.
- enable 1→0: on the next edge the counter returns to 0, state returns to 0, and compareFall pulses for channels that were high.
- rst has priority over enable and tick. rst asserted mid-period restores all reset values on the next edge.
- A prescaleValue change takes effect immediately. If the new value is below psCount, psCount continues until it wraps at its maximum. No shadowing.

## Test plan
- Edge, topValue=9, prescale=0, compare ch0=3:
  - counter cycles 0..9.
  - pwm_out[0] is high 3 of every 10 clks.
  - periodStart pulses every 10 clks; one rise/fall pair per period.
- Center, topValue=4, compare ch0=2:
  - counter sequence 0,1,2,3,4,3,2,1 repeats.
  - pwm_out[0] is high 3 of every 8 clks; periodStart every 8 clks.
- Double buffering: edge, topValue=9, change compare ch0 3→7 at counter==5:
  - the current period still goes low at counter 3.
  - 7 high clks start only after the next periodStart.
- Extremes on topValue=9:
  - compare=0 → constant low, no rise pulses.
  - compare=10 → constant high.
  - invert=1 on the compare=0 channel → constant high.
  - channelEnable=0 → pwm_out equals invert.
- Prescale: prescaleValue=2, topValue=9 → counter advances every 3 clks and periodStart occurs every 30 clks.
- Mid-period disruption:
  - rst with counter==6 → all outputs at reset values on the next edge.
  - enable dropped with a channel high → compareFall pulses once and counterValue=0.
  - Re-enable → counting restarts from 0 with no periodStart pulse.
